// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared LFSR width, Galois tap mask and controller FSM states
package lfsr_pkg;
  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] TAP_MASK = 16'hB400;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;
endpackage

// File: rtl/lfsr_step.sv
// lfsr_step: combinational next-state of the 16-bit Galois LFSR
//   i_state  current state (bit 0 is the spec's s[1])
//   o_next   right shift, XOR TAP_MASK when the shifted-out bit is 1
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] i_state,
  output logic [LFSR_W-1:0] o_next
);
  assign o_next = (i_state >> 1) ^ ({LFSR_W{i_state[0]}} & TAP_MASK);
endmodule

// File: rtl/lfsr_seq_ctrl.sv
// lfsr_seq_ctrl: loads a seed/count, streams CNT_W-bounded LFSR words, pulses done
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_cfg_valid/o_cfg_ready         configuration handshake (i_cfg_seed, i_cfg_count)
//   i_abort                         end the current run without done
//   o_out_valid/i_out_ready         output stream carrying o_out_data
//   o_busy, o_done, o_err_zero_seed run status and one-cycle pulses
//   o_wrap                          pulse on return to seed, only with LFSR_WRAP_DET_EN
module lfsr_seq_ctrl
  import lfsr_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [LFSR_W-1:0] i_cfg_seed,
  input  logic [CNT_W-1:0]  i_cfg_count,
  input  logic              i_abort,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [LFSR_W-1:0] o_out_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_zero_seed,
  output logic              o_wrap
);
  fsm_t              r_fsm, w_fsm_nxt;
  logic [LFSR_W-1:0] r_lfsr, w_next;
  logic [CNT_W-1:0]  r_rem;
  logic              r_err, r_done_z;
  logic              w_cfg_fire, w_load, w_xfer;
  lfsr_step u_step (.i_state(r_lfsr), .o_next(w_next));
  assign w_cfg_fire = (r_fsm == IDLE) && i_cfg_valid;
  assign w_load     = w_cfg_fire && (i_cfg_seed != '0) && (i_cfg_count != '0);
  assign w_xfer     = (r_fsm == RUN) && i_out_ready;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_fsm <= IDLE;
    else          r_fsm <= w_fsm_nxt;
  always_comb
    w_fsm_nxt = (r_fsm == IDLE) ? (w_load ? RUN : IDLE) :
                (r_fsm == RUN)  ? (i_abort ? IDLE : (w_xfer && r_rem == CNT_W'(1)) ? DONE : RUN) :
                IDLE;
  always_comb begin
    o_cfg_ready     = (r_fsm == IDLE);
    o_out_valid     = (r_fsm == RUN);
    o_busy          = (r_fsm == RUN);
    o_out_data      = r_lfsr;
    // count==0 completion happens in IDLE, so it needs its own registered pulse
    o_done          = (r_fsm == DONE) || r_done_z;
    o_err_zero_seed = r_err;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_lfsr   <= '0;
      r_rem    <= '0;
      r_err    <= 1'b0;
      r_done_z <= 1'b0;
    end else begin
      r_err    <= w_cfg_fire && (i_cfg_seed == '0);
      r_done_z <= w_cfg_fire && (i_cfg_seed != '0) && (i_cfg_count == '0);
      if (w_load) begin
        r_lfsr <= i_cfg_seed;
        r_rem  <= i_cfg_count;
      end else if (w_xfer) begin
        r_lfsr <= w_next;
        r_rem  <= r_rem - CNT_W'(1);
      end
    end
`ifdef LFSR_WRAP_DET_EN
  logic [LFSR_W-1:0] r_seed;
  logic              r_wrap;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_seed <= '0;
      r_wrap <= 1'b0;
    end else begin
      if (w_load) r_seed <= i_cfg_seed;
      r_wrap <= w_xfer && (w_next == r_seed);
    end
  assign o_wrap = r_wrap;
`else
  assign o_wrap = 1'b0;
`endif
endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb_lfsr_seq_ctrl: randomized self-checking bench against a word-sequence model
module tb_lfsr_seq_ctrl;
  logic        clk = 0, rst_n = 0;
  logic        cfg_valid = 0, cfg_ready, abort = 0, out_valid, out_ready = 0;
  logic [15:0] cfg_seed = 0, cfg_count = 0, out_data;
  logic        busy, done, err_zero_seed, wrap;
  int          n_chk = 0, n_fail = 0;
  lfsr_seq_ctrl #(.CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_seed(cfg_seed), .i_cfg_count(cfg_count), .i_abort(abort),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data),
    .o_busy(busy), .o_done(done), .o_err_zero_seed(err_zero_seed), .o_wrap(wrap)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [15:0] nxt(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction
  task automatic chk_reset_vals();
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_zero_seed, 0);
    chk("rst_wrap", wrap, 0);
  endtask
  task automatic run(input logic [15:0] seed, input int cnt, input int stall_pct,
                     input int hold_len, input int abort_at, input int reset_at);
    logic [15:0] s;
    int n, cyc, hold;
    bit rdy, ab, ew;
    @(negedge clk);
    chk("idle_cfg_ready", cfg_ready, 1);
    chk("idle_valid", out_valid, 0);
    cfg_valid = 1; cfg_seed = seed; cfg_count = cnt[15:0];
    abort = 1'($urandom_range(1));
    @(negedge clk);
    cfg_valid = 0; abort = 0;
    cfg_seed = 16'($urandom); cfg_count = 16'($urandom);
    if (seed == 0) begin
      chk("zero_err", err_zero_seed, 1);
      chk("zero_valid", out_valid, 0);
      chk("zero_ready", cfg_ready, 1);
      chk("zero_done", done, 0);
      @(negedge clk);
      chk("zero_err_end", err_zero_seed, 0);
      chk("zero_valid2", out_valid, 0);
      chk("zero_ready2", cfg_ready, 1);
      return;
    end
    if (cnt == 0) begin
      chk("cnt0_done", done, 1);
      chk("cnt0_valid", out_valid, 0);
      chk("cnt0_ready", cfg_ready, 1);
      @(negedge clk);
      chk("cnt0_done_end", done, 0);
      return;
    end
    s = seed; n = 0; cyc = 0; hold = 0; ew = 0;
    while (1) begin
      chk("run_valid", out_valid, 1);
      chk("run_data", out_data, s);
      chk("run_busy", busy, 1);
      chk("run_cfg_ready", cfg_ready, 0);
      chk("run_done", done, 0);
      chk("run_wrap", wrap, ew);
      if (n == reset_at) begin
        #2 rst_n = 0;
        #1 chk_reset_vals();
        @(negedge clk);
        rst_n = 1;
        return;
      end
      if (n == 1 && hold < hold_len) begin
        rdy = 0;
        hold++;
      end else rdy = ($urandom_range(99) >= stall_pct);
      ab = rdy && (n + 1 == abort_at);
      out_ready = rdy; abort = ab;
      @(negedge clk);
      out_ready = 0; abort = 0;
      ew = 0;
      if (rdy) begin
`ifdef LFSR_WRAP_DET_EN
        ew = (nxt(s) == seed);
`endif
        s = nxt(s);
        n++;
      end
      cyc++;
      if (ab) begin
        chk("abort_valid", out_valid, 0);
        chk("abort_done", done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_cfg_ready", cfg_ready, 1);
        chk("abort_wrap", wrap, ew);
        @(negedge clk);
        chk("abort_done2", done, 0);
        return;
      end
      if (n == cnt) break;
      if (cyc > cnt * 8 + 100) begin
        chk("timeout", 0, 1);
        return;
      end
    end
    chk("fin_done", done, 1);
    chk("fin_valid", out_valid, 0);
    chk("fin_busy", busy, 0);
    chk("fin_cfg_ready", cfg_ready, 0);
    chk("fin_wrap", wrap, ew);
    @(negedge clk);
    chk("fin_done_end", done, 0);
    chk("fin_cfg_ready2", cfg_ready, 1);
    chk("fin_wrap_end", wrap, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst_n = 1;
    run(16'h0001, 3, 0, 0, -1, -1);
    run(16'h0001, 3, 0, 4, -1, -1);
    run(16'h0000, 5, 0, 0, -1, -1);
    run(16'hACE1, 0, 0, 0, -1, -1);
    run(16'hACE1, 100, 0, 0, 10, -1);
    run(16'h5EED, 20, 20, 0, -1, -1);
    run(16'h1234, 50, 0, 0, -1, 20);
    run(16'h1234, 50, 30, 0, -1, -1);
    for (int i = 0; i < 8; i++)
      run(16'($urandom), $urandom_range(1, 40), $urandom_range(0, 60), 0,
          (i % 3 == 0) ? $urandom_range(1, 10) : -1, -1);
`ifdef LFSR_WRAP_DET_EN
    run(16'hACE1, 65535, 0, 0, -1, -1);
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lfsr_seq_ctrl.md
# lfsr_seq_ctrl

Sequencing controller for the 16-bit Galois LFSR pattern source. It accepts a seed and step count through a valid/ready configuration handshake and steps the LFSR once per accepted output beat. Each state is delivered on a valid/ready output stream, and completion is signalled with a done pulse. It sits between the test/keystream configuration logic and any consumer of pseudo-random words, and is the only agent that loads or advances the LFSR.

## Interface
- CNT_W, 16, width of the step count (max run length 2^CNT_W−1 words)
- clock  input  1  sole clock, rising edge
- reset  input  1  asynchronous, active-low reset
- cfg_valid  input  1  seed/count offered
- cfg_ready  output  1  controller can accept a configuration
- cfg_seed  input  16 [16:1]  LFSR seed
- cfg_count  input  CNT_W  number of words to emit
- abort  input  1  terminate the current run
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  sink accepts the word
- out_data  output  16 [16:1]  current LFSR state
- busy  output  1  run in progress
- done  output  1  one-cycle pulse at normal run completion
- err_zero_seed  output  1  one-cycle pulse when an all-zero seed is rejected
- wrap  output  1  one-cycle pulse when the LFSR returns to its seed (see Configuration)

## Operation
- Step function, 1-based bits: n[16]=s[1]; n[15]=s[16]; n[14]=s[15]^s[1]; n[13]=s[14]^s[1]; n[12]=s[13]; n[11]=s[12]^s[1]; n[10:1]=s[11:2].
- This is a right shift with XOR mask 16'hB400 when s[1]=1. The sequence is maximal length, with period 65535.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cfg_ready=1.
  - On cfg_valid&cfg_ready with seed==0: pulse err_zero_seed and stay in IDLE.
  - With count==0: pulse done and stay in IDLE.
  - Otherwise: load state←seed and rem←count, then go to RUN.
- RUN:
  - out_valid=1, out_data=state, busy=1, cfg_ready=0.
  - On out_valid&out_ready: state←next(state) and rem←rem−1.
  - If rem was 1, go to DONE.
- DONE: done=1 for one cycle, then go to IDLE. out_valid=0.
- abort in RUN: go to IDLE at the next edge with no done pulse.
  - A transfer in the abort cycle counts as delivered; the state still advances.
  - abort in IDLE or DONE is ignored.
- Backpressure: while out_ready=0, out_data and out_valid are held stable.
- rem arithmetic is CNT_W unsigned and never underflows, because rem≥1 in RUN.

## Timing
- All outputs are registered or decoded from registered state only. No combinational path from any input to any output.
- Reset values: cfg_ready=1, out_valid=0, out_data=0, busy=0, done=0, err_zero_seed=0, wrap=0. FSM=IDLE, rem=0.
- Latency:
  - Configuration accepted at edge N → out_valid=1 with out_data=seed in cycle N+1.
  - A word is accepted at each edge where out_valid=out_ready=1.
  - The final accept at edge M → done=1 in cycle M+1, and cfg_ready=1 in cycle M+2.
- Throughput: one word per cycle under continuous out_ready.
- Reset mid-run returns all registers to reset values immediately (asynchronous assertion). Release is synchronous to clock via the existing reset synchroniser.

## Configuration
- LFSR_WRAP_DET_EN defined:
  - A 16-bit seed copy is kept.
  - wrap pulses in the cycle after a transfer whose next(state) equals the seed.
  - The run continues unaffected.
- LFSR_WRAP_DET_EN undefined: seed copy omitted; wrap is tied to 0. The port is always present.

## Structure
- Shared package lfsr_pkg holds:
  - LFSR_W=16
  - TAP_MASK=16'hB400
  - the FSM state enum {IDLE, RUN, DONE}
- Sub-module lfsr_step: a combinational next-state function of the 16-bit state. It is shared with other LFSR users.
- The controller holds the state register, rem counter, FSM and optional seed copy.

## Test plan
- Seed 16'h0001, count 3, out_ready=1 → out_data 16'h0001, 16'hB400, 16'h5A00 on consecutive cycles; done one cycle after the third accept; no wrap.
- Same run with out_ready low for 4 cycles after the first word → 16'hB400 held stable for 4 cycles; total words=3; the sequence is unchanged.
- cfg_seed=0, count 5 → err_zero_seed single pulse; out_valid stays 0; cfg_ready stays 1.
- Seed 16'hACE1, count 100, abort asserted after the 10th accept → out_valid=0 next cycle, no done pulse; a new configuration is accepted afterwards.
- reset asserted mid-run (seed 16'h1234, count 50) → all outputs at reset values immediately; after release, 16'h1234 restarts cleanly from a new configuration.
- LFSR_WRAP_DET_EN on, seed 16'hACE1, count 65535 → wrap and done both pulse in the same cycle after the 65535th accept; with the macro off, wrap stays 0.
